// File: rtl/picmicro_interrupt_controller.sv
// Interrupt entry/exit sequencer for the midrange core: INT pin sync and edge detect, flag-set requests,
// pending/wake evaluation and the vector/flush/hold strobes that steer decoder and program counter.
module picmicro_interrupt_controller #(
    parameter logic [12:0] VECTOR_ADDR = 13'h0004,
    parameter int          SYNC_STAGES = 2,
    parameter int          ENTRY_CLKS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_boundary,
    input  logic [7:0]  intcon_val,
    input  logic [7:0]  pie1_val,
    input  logic [7:0]  pir1_val,
    input  logic        option_intedg,
    input  logic        int_pin,
    input  logic        tmr0if_set_en,
    input  logic        retfie_en,
    input  logic        sleep_active,
    output logic        intcon_set_en,
    output logic [7:0]  intcon_set_mask,
    output logic        gie_clr,
    output logic        vec_en,
    output logic [12:0] vec_addr,
    output logic        core_flush,
    output logic        core_hold,
    output logic        wake,
    output logic        irq_pending
);

    localparam int CNT_W = (ENTRY_CLKS > 1) ? $clog2(ENTRY_CLKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        VECT,
        HOLD
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [SYNC_STAGES-1:0] int_sync;
    logic               int_last;
    logic               int_set_q;
    logic               int_synced;
    logic               int_edge;
    logic               src;

    assign src = (intcon_val[5] & intcon_val[2]) |
                 (intcon_val[4] & intcon_val[1]) |
                 (intcon_val[3] & intcon_val[0]) |
                 (intcon_val[6] & (|(pie1_val & pir1_val)));

    // Combinational outputs are gated by rst so they fall in the same instant the flops clear.
    assign irq_pending = rst & intcon_val[7] & src;
    assign wake        = rst & sleep_active & src;

    // Edge is judged on raw synchronised levels, so flipping option_intedg alone cannot create one.
    assign int_synced = int_sync[SYNC_STAGES-1];
    assign int_edge   = option_intedg ? (int_synced & ~int_last) : (~int_synced & int_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_sync  <= '0;
            int_last  <= 1'b0;
            int_set_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the synchroniser a true shift register regardless of statement order.
            int_sync  <= {int_sync[SYNC_STAGES-2:0], int_pin};
            int_last  <= int_synced;
            int_set_q <= int_edge;
        end
    end

    assign intcon_set_en   = rst & (int_set_q | tmr0if_set_en | retfie_en);
    assign intcon_set_mask = rst ? {retfie_en, 4'b0000, tmr0if_set_en, int_set_q, 1'b0} : 8'h00;
    assign vec_addr        = VECTOR_ADDR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        vec_en     = 1'b0;
        core_flush = 1'b0;
        gie_clr    = 1'b0;
        core_hold  = 1'b0;
        unique case (state)
            IDLE: begin
                // A boundary coinciding with this transition is deliberately not taken.
                if (irq_pending) state_next = PEND;
            end
            PEND: begin
                if (!irq_pending)       state_next = IDLE;
                else if (instr_boundary) state_next = VECT;
            end
            VECT: begin
                vec_en     = 1'b1;
                core_flush = 1'b1;
                gie_clr    = 1'b1;
                core_hold  = 1'b1;
                cnt_next   = CNT_W'(ENTRY_CLKS - 1);
                state_next = HOLD;
            end
            HOLD: begin
                // VECT counts as the first held clock; leave as the counter reaches zero.
                core_hold = 1'b1;
                cnt_next  = cnt - 1'b1;
                if (cnt == CNT_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
